// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: requester bus plus shared-converter hookup for bcd_conv_arbiter
interface bcd_conv_arbiter_if #(parameter int NUM_REQ = 4);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]    req;
   logic [12*NUM_REQ-1:0] bin_in;
   logic [NUM_REQ-1:0]    ack;
   logic [15:0]           bcd_out;
   logic                  bcd_valid;
   logic [IW-1:0]         bcd_id;
   logic                  busy;
   logic [11:0]           conv_bin;
   logic [15:0]           conv_bcd;
   modport master (output req, bin_in, conv_bcd, input ack, bcd_out, bcd_valid, bcd_id, busy, conv_bin);
   modport slave  (input req, bin_in, conv_bcd, output ack, bcd_out, bcd_valid, bcd_id, busy, conv_bin);
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one external binary-to-BCD converter
module bcd_conv_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int CONV_LAT = 0
) (
   input logic clk,
   input logic rst,
   bcd_conv_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IW-1:0]      ptr_q, ptr_d, id_q, id_d, g, idx;
   logic [11:0]        conv_bin_q, conv_bin_d;
   logic [15:0]        bcd_out_q, bcd_out_d;
   logic [NUM_REQ-1:0] ack_q, ack_d, elig;
   logic               grant, done;
   // a requester acked this cycle may not be re-granted on the same edge
   assign elig = bus.req & ~ack_q;
   always_comb begin
      g = ptr_q;
      idx = ptr_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (elig[idx]) g = idx;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         id_q       <= '0;
         conv_bin_q <= '0;
         bcd_out_q  <= '0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         conv_bin_q <= conv_bin_d;
         bcd_out_q  <= bcd_out_d;
         ack_q      <= ack_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE) ? ((|elig) ? WAIT : IDLE) : ((cnt_q == 4'd0) ? IDLE : WAIT);
   end
   always_comb begin
      grant      = (state_q == IDLE) && (|elig);
      done       = (state_q == WAIT) && (cnt_q == 4'd0);
      conv_bin_d = grant ? bus.bin_in[12*int'(g) +: 12] : conv_bin_q;
      id_d       = grant ? g : id_q;
      cnt_d      = grant ? 4'(CONV_LAT) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      bcd_out_d  = done ? bus.conv_bcd : bcd_out_q;
      ack_d      = done ? NUM_REQ'(1) << id_q : '0;
      ptr_d      = done ? id_q : ptr_q;
   end
   assign bus.ack       = ack_q;
   assign bus.bcd_valid = |ack_q;
   assign bus.bcd_id    = id_q;
   assign bus.busy      = (state_q == WAIT);
   assign bus.conv_bin  = conv_bin_q;
   assign bus.bcd_out   = bcd_out_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed and random checks of bcd_conv_arbiter at CONV_LAT 0 and 3
module tb_bcd_conv_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   bcd_conv_arbiter_if #(.NUM_REQ(4)) bus0 ();
   bcd_conv_arbiter_if #(.NUM_REQ(4)) bus3 ();
   bcd_conv_arbiter #(.NUM_REQ(4), .CONV_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   bcd_conv_arbiter #(.NUM_REQ(4), .CONV_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
   int n_chk = 0;
   int n_fail = 0;
   int last0 = 3;
   int last3 = 3;
   logic [11:0] d3 [3];
   function automatic logic [15:0] to_bcd(input logic [11:0] v);
      int x;
      x = int'(v);
      return {4'(x / 1000), 4'(x / 100 % 10), 4'(x / 10 % 10), 4'(x % 10)};
   endfunction
   assign bus0.conv_bcd = to_bcd(bus0.conv_bin);
   // slow converter: output follows conv_bin three cycles late
   always @(posedge clk) begin
      d3[0] <= bus3.conv_bin;
      d3[1] <= d3[0];
      d3[2] <= d3[1];
   end
   assign bus3.conv_bcd = to_bcd(d3[2]);
   function automatic int rr(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wait_ack(input bit s, output int id, output int cyc);
      logic [3:0] a;
      cyc = 0;
      id = -1;
      do begin
         @(negedge clk);
         cyc++;
         a = s ? bus3.ack : bus0.ack;
      end while (a == 4'd0 && cyc < 40);
      if ($countones(a) == 1) for (int i = 0; i < 4; i++) if (a[i]) id = i;
      chk("valid_eq_ack", s ? bus3.bcd_valid : bus0.bcd_valid, 32'(|a));
   endtask
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int id, cyc, e;
      logic [3:0] nr, ab;
      logic [15:0] exp;
      bus0.req = '1;
      bus3.req = '1;
      bus0.bin_in = '0;
      bus3.bin_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", bus0.ack, 0);
      chk("rst_busy", bus0.busy, 0);
      chk("rst_bcd", bus0.bcd_out, 0);
      chk("rst_conv_bin", bus0.conv_bin, 0);
      chk("rst_id", bus0.bcd_id, 0);
      chk("rst_ack3", bus3.ack, 0);
      chk("rst_busy3", bus3.busy, 0);
      bus0.req = '0;
      bus3.req = '0;
      rst = 1'b0;
      bus0.bin_in[11:0] = 12'd4095;
      bus0.req = 4'b0001;
      wait_ack(0, id, cyc);
      chk("single_id", id, 0);
      chk("single_lat", cyc, 2);
      chk("single_bcd", bus0.bcd_out, 16'h4095);
      chk("single_bcd_id", bus0.bcd_id, 0);
      bus0.req = '0;
      @(negedge clk);
      chk("single_pulse", bus0.ack, 0);
      chk("single_idle", bus0.busy, 0);
      bus0.bin_in[11:0] = 12'd0;
      bus0.req = 4'b0001;
      wait_ack(0, id, cyc);
      chk("zero_bcd", bus0.bcd_out, 16'h0000);
      bus0.req = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last0 = 3;
      bus0.bin_in = {12'd1234, 12'd999, 12'd80, 12'd7};
      bus0.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         e = rr(bus0.req, last0);
         wait_ack(0, id, cyc);
         chk("contend_model", id, e);
         chk("contend_order", id, k);
         chk("contend_gap", cyc, 2);
         chk("contend_bcd", bus0.bcd_out, to_bcd(bus0.bin_in[12*e +: 12]));
         bus0.req[e] = 1'b0;
         last0 = e;
      end
      bus0.req = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         e = rr(bus0.req & ~(4'd1 << last0), last0);
         wait_ack(0, id, cyc);
         chk("fair_model", id, e);
         chk("fair_alt", id, (k % 2 == 0) ? 1 : 3);
         chk("fair_bcd", bus0.bcd_out, to_bcd(bus0.bin_in[12*e +: 12]));
         last0 = e;
      end
      bus0.req = '0;
      @(negedge clk);
      chk("fair_idle", bus0.busy, 0);
      ab = '0;
      for (int k = 0; k < 40; k++) begin
         nr = (bus0.req & ~ab) | (4'($urandom) & ~ab);
         if (nr == 4'd0) nr = 4'd1 << ((last0 + 1) % 4);
         bus0.req = nr;
         bus0.bin_in = {16'($urandom), $urandom};
         e = rr(nr, last0);
         exp = to_bcd(bus0.bin_in[12*e +: 12]);
         @(negedge clk);
         chk("rand_busy", bus0.busy, 1);
         chk("rand_conv_bin", bus0.conv_bin, bus0.bin_in[12*e +: 12]);
         bus0.bin_in = {16'($urandom), $urandom};
         wait_ack(0, id, cyc);
         chk("rand_lat", cyc, 1);
         chk("rand_id", id, e);
         chk("rand_bcd_id", bus0.bcd_id, e);
         chk("rand_bcd", bus0.bcd_out, exp);
         last0 = e;
         ab = 4'd1 << e;
      end
      bus0.req = '0;
      @(negedge clk);
      bus3.bin_in[35:24] = 12'd512;
      bus3.req = 4'b0100;
      wait_ack(1, id, cyc);
      chk("lat3_cyc", cyc, 5);
      chk("lat3_id", id, 2);
      chk("lat3_bcd", bus3.bcd_out, 16'h0512);
      bus3.req = '0;
      last3 = 2;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         nr = 4'($urandom);
         if (nr == 4'd0) nr = 4'b1000;
         bus3.req = nr;
         bus3.bin_in = {16'($urandom), $urandom};
         e = rr(nr, last3);
         exp = to_bcd(bus3.bin_in[12*e +: 12]);
         @(negedge clk);
         bus3.bin_in = {16'($urandom), $urandom};
         wait_ack(1, id, cyc);
         chk("rand3_lat", cyc, 4);
         chk("rand3_id", id, e);
         chk("rand3_bcd", bus3.bcd_out, exp);
         bus3.req = '0;
         last3 = e;
         @(negedge clk);
      end
      bus3.bin_in[11:0] = 12'($urandom);
      bus3.req = 4'b0001;
      repeat (2) @(negedge clk);
      chk("abort3_busy", bus3.busy, 1);
      rst = 1'b1;
      bus3.req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort3_idle", bus3.busy, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort3_no_ack", bus3.ack, 0);
      end
      bus3.bin_in[23:12] = 12'($urandom);
      bus3.req = 4'b0010;
      wait_ack(1, id, cyc);
      chk("abort3_next_id", id, 1);
      chk("abort3_next_lat", cyc, 5);
      chk("abort3_next_bcd", bus3.bcd_out, to_bcd(bus3.bin_in[23:12]));
      bus3.req = '0;
      bus0.bin_in[11:0] = 12'($urandom);
      bus0.req = 4'b0001;
      @(negedge clk);
      chk("abort0_busy", bus0.busy, 1);
      rst = 1'b1;
      bus0.req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort0_no_ack", bus0.ack, 0);
      chk("abort0_idle", bus0.busy, 0);
      chk("abort0_bcd", bus0.bcd_out, 0);
      @(negedge clk);
      chk("abort0_no_ack2", bus0.ack, 0);
      bus0.bin_in[23:12] = 12'($urandom);
      bus0.req = 4'b0010;
      wait_ack(0, id, cyc);
      chk("abort0_next_id", id, 1);
      chk("abort0_next_lat", cyc, 2);
      chk("abort0_next_bcd", bus0.bcd_out, to_bcd(bus0.bin_in[23:12]));
      bus0.req = '0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
